// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative RV32M-style multiply/divide unit. It runs one radix-2
//            step per cycle on operand magnitudes, using shift-add for
//            multiply and restoring division for divide. It then applies the
//            result sign and the special cases. Latency is always 33 cycles
//            from the accepting edge to the Done pulse.
// Ports    : clk_n  - clock; all state changes on its rising edge
//            rst_n  - synchronous reset, active-high (1 = reset)
//            Start  - begin an operation (only sampled in IDLE)
//            Op     - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                     100 DIV, 101 DIVU, 110 REM, 111 REMU
//            BusA   - rs1 operand
//            BusB   - rs2 operand
//            RdIn   - destination register tag
//            Flush  - abort the in-flight operation
//            Busy   - unit occupied (CALC or DONE)
//            Done   - one-cycle result-valid pulse
//            Wen    - regfile write enable (Done and Rd != 0)
//            Rd     - regfile write address
//            BusW   - regfile write data
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_n,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [4:0]       RdIn,
   input  logic             Flush,
   output logic             Busy,
   output logic             Done,
   output logic             Wen,
   output logic [4:0]       Rd,
   output logic [WIDTH-1:0] BusW
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [4:0] LAST_STEP = 5'd31;

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
   function automatic logic sign_a(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM.
   function automatic logic sign_b(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   logic [1:0]         state_q, state_d;
   logic [4:0]         cnt_q,   cnt_d;
   logic [2:0]         op_q,    op_d;
   logic [WIDTH-1:0]   a_q,     a_d;
   logic [WIDTH-1:0]   b_q,     b_d;
   logic [4:0]         rd_q,    rd_d;
   // Multiply: {partial high, remaining multiplier bits / low product}.
   // Divide  : {partial remainder, dividend bits / quotient bits}.
   logic [2*WIDTH-1:0] prod_q,  prod_d;

   logic [WIDTH-1:0]   mag_a_in;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_step;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_signed, rem_signed;
   logic [WIDTH-1:0]   result;
   logic               out_en;

   // Magnitude of the incoming rs1, loaded into the low half at acceptance.
   assign mag_a_in = (sign_a(Op) && BusA[WIDTH-1]) ? -BusA : BusA;

   assign neg_a = sign_a(op_q) & a_q[WIDTH-1];
   assign neg_b = sign_b(op_q) & b_q[WIDTH-1];
   assign mag_b = neg_b ? -b_q : b_q;

   // Shift-add step: conditionally add the multiplicand into the high half,
   // then shift the whole register right by one (carry lands in bit 2W-1).
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_b} : '0);
   assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

   // Restoring step: the shifted partial remainder is 33 bits wide.
   // When it is >= the divisor, the true difference fits in WIDTH bits,
   // so the modular subtraction on the low WIDTH bits is exact.
   assign div_ge   = prod_q[2*WIDTH-1:WIDTH-1] >= {1'b0, mag_b};
   assign div_rem  = prod_q[2*WIDTH-2:WIDTH-1] - mag_b;
   assign div_step = div_ge ? {div_rem, prod_q[WIDTH-2:0], 1'b1}
                            : {prod_q[2*WIDTH-2:0], 1'b0};

   // A zero divisor yields an all-ones magnitude quotient. Sign correction
   // would corrupt that, so the divide-by-zero results are forced below.
   // Signed overflow needs no special case: magnitude 2^31 / 1 gives
   // 0x80000000 with a positive sign and a zero remainder.
   assign prod_signed = (neg_a ^ neg_b) ? -prod_q : prod_q;
   assign quo_signed  = (neg_a ^ neg_b) ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
   assign rem_signed  = neg_a ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

   always_comb begin
      result = '0;
      case (op_q)
         OP_MUL:                      result = prod_signed[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = prod_signed[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:             result = (b_q == '0) ? '1  : quo_signed;
         OP_REM, OP_REMU:             result = (b_q == '0) ? a_q : rem_signed;
         default:                     result = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      prod_d  = prod_q;
      case (state_q)
         S_IDLE: begin
            // Flush outranks Start.
            if (Start && !Flush) begin
               op_d    = Op;
               a_d     = BusA;
               b_d     = BusB;
               rd_d    = RdIn;
               cnt_d   = '0;
               prod_d  = {{WIDTH{1'b0}}, mag_a_in};
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (Flush) begin
               state_d = S_IDLE;
            end else begin
               prod_d = op_q[2] ? div_step : mul_step;
               cnt_d  = cnt_q + 5'd1;
               if (cnt_q == LAST_STEP) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_n) begin
      if (rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         prod_q  <= prod_d;
      end
   end

   // A Flush or reset arriving during DONE suppresses that cycle's write.
   assign out_en = (state_q == S_DONE) && !Flush && !rst_n;

   assign Busy = (state_q != S_IDLE);
   assign Done = out_en;
   assign Wen  = out_en && (rd_q != 5'd0);
   assign Rd   = out_en ? rd_q   : 5'd0;
   assign BusW = out_en ? result : '0;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed self-checking bench for mul_div_unit. Each vector
//            carries a hand-computed expected result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   logic        clk_n;
   logic        rst_n;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] BusA;
   logic [31:0] BusB;
   logic [4:0]  RdIn;
   logic        Flush;
   logic        Busy;
   logic        Done;
   logic        Wen;
   logic [4:0]  Rd;
   logic [31:0] BusW;

   int n_vec;
   int n_err;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk_n (clk_n),
      .rst_n (rst_n),
      .Start (Start),
      .Op    (Op),
      .BusA  (BusA),
      .BusB  (BusB),
      .RdIn  (RdIn),
      .Flush (Flush),
      .Busy  (Busy),
      .Done  (Done),
      .Wen   (Wen),
      .Rd    (Rd),
      .BusW  (BusW)
   );

   initial clk_n = 1'b0;
   always #5 clk_n = ~clk_n;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one cycle; the bench acts 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk_n);
      #1;
   endtask

   task automatic scramble();
      Op   = 3'($urandom_range(0, 7));
      BusA = $urandom();
      BusB = $urandom();
      RdIn = 5'($urandom_range(0, 31));
   endtask

   // Present a request, let the accepting edge pass, and leave the bench in cycle 1.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
      Start = 1'b1;
      Op    = op;
      BusA  = a;
      BusB  = b;
      RdIn  = rd;
      tick();
      Start = 1'b0;
      scramble();
   endtask

   // From cycle 1, expect Busy through cycle 33 and the result only in cycle 33.
   // Then step into cycle 34 and expect IDLE.
   task automatic expect_result(input string tag, input logic [4:0] rd,
                                input logic [31:0] w, input logic wen);
      int early_done;
      int busy_lo;
      early_done = 0;
      busy_lo    = 0;
      for (int k = 1; k < 33; k++) begin
         if (Done || Wen) early_done++;
         if (!Busy)       busy_lo++;
         scramble();
         tick();
      end
      check({tag, " early_done"}, 32'(early_done), 32'd0);
      check({tag, " busy_low"},   32'(busy_lo),    32'd0);
      check({tag, " busy33"},     32'(Busy),       32'd1);
      check({tag, " done"},       32'(Done),       32'd1);
      check({tag, " wen"},        32'(Wen),        32'(wen));
      check({tag, " rd"},         32'(Rd),         32'(rd));
      check({tag, " busw"},       BusW,            w);
      tick();
      check({tag, " idle_busy"},  32'(Busy),       32'd0);
      check({tag, " idle_done"},  32'(Done),       32'd0);
   endtask

   initial begin
      int cnt;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b1;
      Start = 1'b0;
      Op    = 3'b000;
      BusA  = 32'd0;
      BusB  = 32'd0;
      RdIn  = 5'd0;
      Flush = 1'b0;

      // Reset state
      tick(); tick(); tick();
      check("rst busy", 32'(Busy), 32'd0);
      check("rst done", 32'(Done), 32'd0);
      check("rst wen",  32'(Wen),  32'd0);
      check("rst rd",   32'(Rd),   32'd0);
      check("rst busw", BusW,      32'd0);
      rst_n = 1'b0;

      // Multiply family
      start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
      expect_result("mul", 5'd5, 32'hFFFF_FFEB, 1'b1);
      start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      expect_result("mulhu", 5'd1, 32'hFFFF_FFFE, 1'b1);
      start_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      expect_result("mulh", 5'd2, 32'h0000_0000, 1'b1);
      start_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3);
      expect_result("mulhsu", 5'd3, 32'hFFFF_FFFF, 1'b1);
      start_op(OP_MUL, 32'h0001_0003, 32'h0002_0005, 5'd31);
      expect_result("mul_big", 5'd31, 32'h000B_000F, 1'b1);

      // Divide family and special cases
      start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10);
      expect_result("div", 5'd10, 32'hFFFF_FFFD, 1'b1);
      start_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
      expect_result("rem", 5'd11, 32'hFFFF_FFFF, 1'b1);
      start_op(OP_DIVU, 32'd100, 32'd0, 5'd12);
      expect_result("divu0", 5'd12, 32'hFFFF_FFFF, 1'b1);
      start_op(OP_REMU, 32'd100, 32'd0, 5'd13);
      expect_result("remu0", 5'd13, 32'd100, 1'b1);
      start_op(OP_DIV, 32'hFFFF_FF9C, 32'd0, 5'd17);
      expect_result("div0_neg", 5'd17, 32'hFFFF_FFFF, 1'b1);
      start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
      expect_result("div_ovf", 5'd14, 32'h8000_0000, 1'b1);
      start_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
      expect_result("rem_ovf", 5'd15, 32'h0000_0000, 1'b1);
      start_op(OP_REMU, 32'hFFFF_FFFF, 32'd10, 5'd16);
      expect_result("remu", 5'd16, 32'd5, 1'b1);
      start_op(OP_DIVU, 32'd10, 32'd3, 5'd0);
      expect_result("divu_rd0", 5'd0, 32'd3, 1'b0);

      // A second Start during CALC is ignored; the held request is taken after DONE.
      start_op(OP_MUL, 32'd3, 32'd4, 5'd7);
      cnt = 0;
      for (int k = 1; k < 33; k++) begin
         if (k == 5) begin
            Start = 1'b1;
            Op    = OP_DIVU;
            BusA  = 32'd100;
            BusB  = 32'd7;
            RdIn  = 5'd9;
         end
         if (Done) cnt++;
         tick();
      end
      check("busy2 early_done", 32'(cnt), 32'd0);
      check("busy2 done", 32'(Done), 32'd1);
      check("busy2 rd",   32'(Rd),   32'd7);
      check("busy2 busw", BusW,      32'd12);
      tick();
      check("busy2 idle", 32'(Busy), 32'd0);
      tick();
      Start = 1'b0;
      scramble();
      expect_result("second", 5'd9, 32'd14, 1'b1);

      // Flush in CALC at cycle 10
      start_op(OP_DIV, 32'd50, 32'd5, 5'd3);
      for (int k = 1; k < 10; k++) tick();
      Flush = 1'b1;
      #1;
      check("flush10 done", 32'(Done), 32'd0);
      tick();
      Flush = 1'b0;
      check("flush11 busy", 32'(Busy), 32'd0);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (Done || Wen || Busy) cnt++;
         tick();
      end
      check("flush no_write", 32'(cnt), 32'd0);

      // Flush has priority over Start in IDLE
      Flush = 1'b1;
      Start = 1'b1;
      tick();
      Flush = 1'b0;
      Start = 1'b0;
      check("flush_start busy", 32'(Busy), 32'd0);

      // Flush coinciding with DONE suppresses the write
      start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
      for (int k = 1; k < 33; k++) tick();
      check("flushd done_pre", 32'(Done), 32'd1);
      Flush = 1'b1;
      #1;
      check("flushd done", 32'(Done), 32'd0);
      check("flushd wen",  32'(Wen),  32'd0);
      tick();
      Flush = 1'b0;
      check("flushd busy", 32'(Busy), 32'd0);

      // Reset at cycle 20 discards the op; the Start right after reset is accepted.
      start_op(OP_MUL, 32'd6, 32'd7, 5'd4);
      cnt = 0;
      for (int k = 1; k < 20; k++) begin
         if (Done || Wen) cnt++;
         tick();
      end
      rst_n = 1'b1;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("rst20 early", 32'(cnt), 32'd0);
      check("rst21 busy", 32'(Busy), 32'd0);
      check("rst21 done", 32'(Done), 32'd0);
      check("rst21 wen",  32'(Wen),  32'd0);
      check("rst21 rd",   32'(Rd),   32'd0);
      check("rst21 busw", BusW,      32'd0);
      rst_n = 1'b0;
      start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6);
      expect_result("post_rst", 5'd6, 32'hFFFF_FFFD, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
